// File: rtl/qam16_mapper_if.sv
// Bit-stream and symbol handshake bundle for the 16-QAM mapper.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
interface qam16_mapper_if #(
    parameter int WIDTH = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             bit_last;
    logic             bit_ready;
    logic [WIDTH-1:0] in_phase;
    logic [WIDTH-1:0] quad_phase;
    logic             sym_valid;
    logic             sym_ready;
    logic             sym_last;
    logic             sym_pad;
    logic [15:0]      sym_count;

    modport master (
        output bit_in, bit_valid, bit_last, sym_ready,
        input  bit_ready, in_phase, quad_phase, sym_valid, sym_last, sym_pad, sym_count
    );

    modport slave (
        input  bit_in, bit_valid, bit_last, sym_ready,
        output bit_ready, in_phase, quad_phase, sym_valid, sym_last, sym_pad, sym_count
    );
endinterface

// File: rtl/qam16_mapper.sv
// Serial-bit to 16-QAM symbol mapper: packs bits MSB first into nibbles, maps them
// to I/Q levels and queues {I,Q,last,pad} in a small FIFO for the IFFT loader.
module qam16_mapper #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    qam16_mapper_if.slave    bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] i;
        logic [WIDTH-1:0] q;
        logic             last;
        logic             pad;
    } sym_t;

    logic [1:0]  r_bit_cnt;
    logic [3:0]  r_nibble;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [15:0] r_sym_count;
    sym_t        r_mem [FIFO_DEPTH];

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [3:0]  w_nibble;
    sym_t        w_sym;
    sym_t        w_head;

    function automatic logic [WIDTH-1:0] map_i(input logic [1:0] b);
        case (b)
            2'b00:   map_i = WIDTH'(16'h0014);
            2'b01:   map_i = WIDTH'(16'h000a);
            2'b10:   map_i = WIDTH'(16'h0028);
            default: map_i = WIDTH'(16'h001e);
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] map_q(input logic [1:0] b);
        case (b)
            2'b00:   map_q = WIDTH'(16'h0028);
            2'b01:   map_q = WIDTH'(16'h001e);
            2'b10:   map_q = WIDTH'(16'h0014);
            default: map_q = WIDTH'(16'h000a);
        endcase
    endfunction

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_accept = bus.bit_valid && !w_full;
    assign w_push   = w_accept && ((r_bit_cnt == 2'd3) || bus.bit_last);
    assign w_pop    = !w_empty && bus.sym_ready;

    // Unfilled LSBs are already 0 because the nibble register clears on every push.
    always_comb begin
        w_nibble                    = r_nibble;
        w_nibble[2'd3 - r_bit_cnt]  = bus.bit_in;
    end

    assign w_sym  = {map_i(w_nibble[1:0]), map_q(w_nibble[3:2]), bus.bit_last, (r_bit_cnt != 2'd3)};
    assign w_head = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= 2'd0;
            r_nibble    <= 4'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_sym_count <= 16'd0;
        end else begin
            if (w_accept) begin
                if (w_push) begin
                    r_bit_cnt <= 2'd0;
                    r_nibble  <= 4'd0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 2'd1;
                    r_nibble  <= w_nibble;
                end
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_sym_count <= r_sym_count + 16'd1;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_sym;
    end

    assign bus.bit_ready  = !w_full;
    assign bus.sym_valid  = !w_empty;
    assign bus.in_phase   = w_empty ? '0 : w_head.i;
    assign bus.quad_phase = w_empty ? '0 : w_head.q;
    assign bus.sym_last   = w_empty ? 1'b0 : w_head.last;
    assign bus.sym_pad    = w_empty ? 1'b0 : w_head.pad;
    assign bus.sym_count  = r_sym_count;
endmodule
